register_access_controller: RTL and testbench
=============================================

REGISTER_ACCESS_CONTROLLER -- requirements
Module: register_access_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of the byte stream and of register data.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 4, the register address width (16 registers).
REQ-003 SHALL have parameter WRITE_COMMAND, default 8'hAA, the frame opcode for a register write.
REQ-004 SHALL have parameter READ_COMMAND, default 8'hBB, the frame opcode for a register read.
REQ-005 SHALL have port clk  input  1  system clock, rising edge active.
REQ-006 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-007 SHALL have port rx_data  input  DATA_WIDTH  received byte.
REQ-008 SHALL have port rx_data_valid  input  1  one-cycle pulse qualifying rx_data.
REQ-009 SHALL have port address  output  ADDRESS_WIDTH  register file address.
REQ-010 SHALL have port write_enable  output  1  register write strobe.
REQ-011 SHALL have port write_data  output  DATA_WIDTH  register write data.
REQ-012 SHALL have port read_enable  output  1  register read strobe.
REQ-013 SHALL have port read_data  input  DATA_WIDTH  register read data.
REQ-014 SHALL have port read_data_valid  input  1  qualifies read_data.
REQ-015 SHALL have port tx_data  output  DATA_WIDTH  byte to the transmitter.
REQ-016 SHALL have port tx_data_valid  output  1  one-cycle pulse qualifying tx_data.
REQ-017 SHALL have port tx_busy  input  1  transmitter cannot accept a byte.
REQ-018 SHALL have port frame_error  output  1  one-cycle pulse on a dropped byte or a read timeout.

Function
REQ-019 SHALL implement the states IDLE, WRITE_ADDRESS, WRITE_DATA, READ_ADDRESS, READ_WAIT and SEND, and SHALL drive every output from a register.
REQ-020 IDLE: a byte equal to WRITE_COMMAND SHALL go to WRITE_ADDRESS, a byte equal to READ_COMMAND SHALL go to READ_ADDRESS, and any other byte SHALL be ignored silently.
REQ-021 WRITE_ADDRESS: the next byte's low ADDRESS_WIDTH bits SHALL latch into address, with upper bits discarded, and the state SHALL go to WRITE_DATA.
REQ-022 WRITE_DATA: on the next byte, write_data SHALL take that byte and write_enable SHALL be high for exactly the following cycle, with address stable; the state SHALL then return to IDLE.
REQ-023 READ_ADDRESS: on the next byte, address SHALL latch, read_enable SHALL be high for exactly the following cycle, and the state SHALL go to READ_WAIT.
REQ-024 READ_WAIT: a 3-bit cycle counter SHALL start at 0; when read_data_valid is sampled high, read_data SHALL be captured into tx_data and the state SHALL go to SEND.
REQ-025 READ_WAIT timeout: if read_data_valid is not seen within 4 cycles after the read_enable cycle, the block SHALL pulse frame_error once and return to IDLE, with tx_data unchanged.
REQ-026 SEND: in the first cycle with tx_busy sampled low, tx_data_valid SHALL pulse for one cycle and the state SHALL return to IDLE; while tx_busy is high the block SHALL wait indefinitely, with tx_data held.
REQ-027 Minimum latency from the read address byte to tx_data_valid SHALL be 3 cycles when read_data_valid returns one cycle after read_enable and tx_busy is low.
REQ-028 A byte arriving in READ_WAIT or SEND SHALL be dropped, and frame_error SHALL pulse in the following cycle.
REQ-029 write_enable and read_enable SHALL never be high in the same cycle.
REQ-030 Each strobe SHALL never be high for two consecutive cycles.
REQ-031 A byte arriving in the cycle a strobe is asserted SHALL be processed normally, since the state has already returned to IDLE or READ_WAIT.
REQ-032 address and write_data SHALL hold their last values between frames.

Reset
REQ-033 While reset is low, the state SHALL be IDLE and address, write_data, tx_data and the counter SHALL be 0.
REQ-034 While reset is low, write_enable, read_enable, tx_data_valid and frame_error SHALL be 0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame, and the next byte after release SHALL be decoded as an opcode.

Verification
REQ-036 Write frame: bytes AA,03,5C -> one cycle of write_enable=1, address=3, write_data=5C; no tx_data_valid.
REQ-037 Read frame: bytes BB,02; responder returns read_data=21 with valid one cycle after read_enable -> tx_data=21 with a tx_data_valid pulse 3 cycles after byte 02.
REQ-038 Backpressure: read of address 1 with tx_busy high for 10 cycles -> tx_data_valid pulses in the first cycle after tx_busy falls, exactly once.
REQ-039 Timeout: BB,07 with read_data_valid never asserted -> frame_error pulses once 5 cycles after read_enable, state returns to IDLE, and a subsequent AA,00,FF completes normally.
REQ-040 Junk and drop: byte 3C in IDLE -> no outputs; a byte sent during READ_WAIT -> frame_error pulse, read completes normally.
REQ-041 Reset mid-frame: AA,04, then reset pulse, then 11,22 -> no write_enable, no outputs.

Source files
------------

// File: rtl/register_access_controller_if.sv
// Bundle of the byte-stream, register-file and transmitter signals around
// register_access_controller.
//   master : the controller side (drives address/strobes/tx, receives bytes)
//   slave  : the environment side (byte source, register file, transmitter)
interface register_access_controller_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]    rx_data;
  logic                     rx_data_valid;
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     write_enable;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     read_enable;
  logic [DATA_WIDTH-1:0]    read_data;
  logic                     read_data_valid;
  logic [DATA_WIDTH-1:0]    tx_data;
  logic                     tx_data_valid;
  logic                     tx_busy;
  logic                     frame_error;

  modport master (
    input  rx_data, rx_data_valid, read_data, read_data_valid, tx_busy,
    output address, write_enable, write_data, read_enable,
           tx_data, tx_data_valid, frame_error
  );

  modport slave (
    output rx_data, rx_data_valid, read_data, read_data_valid, tx_busy,
    input  address, write_enable, write_data, read_enable,
           tx_data, tx_data_valid, frame_error
  );
endinterface

// File: rtl/register_access_controller.sv
// Decodes a received byte stream into register-file accesses.
//   Write frame : WRITE_COMMAND, address, data  -> one-cycle write_enable
//   Read frame  : READ_COMMAND, address         -> one-cycle read_enable, then
//                 the returned read_data is forwarded to the transmitter.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   bus    - master modport of register_access_controller_if carrying the
//            rx byte stream, register-file strobes/data and tx handshake.
// All outputs come straight from registers.
module register_access_controller #(
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter int unsigned           ADDRESS_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WRITE_COMMAND = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] READ_COMMAND  = 8'hBB
) (
  input logic                          clk,
  input logic                          reset,
  register_access_controller_if.master bus
);

  localparam int unsigned      CNT_W       = 3;
  // Last READ_WAIT count at which read_data_valid is still accepted.
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(4);

  typedef enum logic [2:0] {
    IDLE,
    WRITE_ADDRESS,
    WRITE_DATA,
    READ_ADDRESS,
    READ_WAIT,
    SEND
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
  logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     write_enable_q, write_enable_d;
  logic                     read_enable_q, read_enable_d;
  logic                     tx_data_valid_q, tx_data_valid_d;
  logic                     frame_error_q, frame_error_d;

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      address_q       <= '0;
      write_data_q    <= '0;
      tx_data_q       <= '0;
      cnt_q           <= '0;
      write_enable_q  <= 1'b0;
      read_enable_q   <= 1'b0;
      tx_data_valid_q <= 1'b0;
      frame_error_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      address_q       <= address_d;
      write_data_q    <= write_data_d;
      tx_data_q       <= tx_data_d;
      cnt_q           <= cnt_d;
      write_enable_q  <= write_enable_d;
      read_enable_q   <= read_enable_d;
      tx_data_valid_q <= tx_data_valid_d;
      frame_error_q   <= frame_error_d;
    end
  end

  // Frame decoding, next state and next register values.
  always_comb begin
    state_d         = state_q;
    address_d       = address_q;
    write_data_d    = write_data_q;
    tx_data_d       = tx_data_q;
    cnt_d           = cnt_q;
    write_enable_d  = 1'b0;
    read_enable_d   = 1'b0;
    tx_data_valid_d = 1'b0;
    frame_error_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_data_valid) begin
          if (bus.rx_data == WRITE_COMMAND) begin
            state_d = WRITE_ADDRESS;
          end else if (bus.rx_data == READ_COMMAND) begin
            state_d = READ_ADDRESS;
          end
        end
      end

      WRITE_ADDRESS: begin
        if (bus.rx_data_valid) begin
          address_d = bus.rx_data[ADDRESS_WIDTH-1:0];
          state_d   = WRITE_DATA;
        end
      end

      WRITE_DATA: begin
        if (bus.rx_data_valid) begin
          write_data_d   = bus.rx_data;
          write_enable_d = 1'b1;
          state_d        = IDLE;
        end
      end

      READ_ADDRESS: begin
        if (bus.rx_data_valid) begin
          address_d     = bus.rx_data[ADDRESS_WIDTH-1:0];
          read_enable_d = 1'b1;
          cnt_d         = '0;
          state_d       = READ_WAIT;
        end
      end

      // Bytes arriving here are dropped and flagged; a late response times out.
      READ_WAIT: begin
        frame_error_d = bus.rx_data_valid;
        if (bus.read_data_valid) begin
          tx_data_d = bus.read_data;
          state_d   = SEND;
        end else if (cnt_q == TIMEOUT_CNT) begin
          frame_error_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end

      SEND: begin
        frame_error_d = bus.rx_data_valid;
        if (!bus.tx_busy) begin
          tx_data_valid_d = 1'b1;
          state_d         = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.address       = address_q;
  assign bus.write_enable  = write_enable_q;
  assign bus.write_data    = write_data_q;
  assign bus.read_enable   = read_enable_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_data_valid = tx_data_valid_q;
  assign bus.frame_error   = frame_error_q;

endmodule

// File: tb/tb_register_access_controller.sv
// Self-checking bench for register_access_controller: a vector table for the
// basic write/read frames, hand-written multi-cycle corner sequences, and a
// randomized run compared cycle by cycle against a frame-level model.
module tb_register_access_controller;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam logic [7:0]  WR = 8'hAA;
  localparam logic [7:0]  RD = 8'hBB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  register_access_controller_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  register_access_controller #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WRITE_COMMAND(WR), .READ_COMMAND(RD)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic [3:0] addr;
    logic       we;
    logic [7:0] wd;
    logic       re;
    logic [7:0] txd;
    logic       tv;
    logic       fe;
  } out_t;

  typedef struct {
    logic       rv;
    logic [7:0] rx;
    logic       rdv;
    logic [7:0] rd;
    logic       busy;
    out_t       exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic out_t get_out();
    out_t o;
    o.addr = bus.address;
    o.we   = bus.write_enable;
    o.wd   = bus.write_data;
    o.re   = bus.read_enable;
    o.txd  = bus.tx_data;
    o.tv   = bus.tx_data_valid;
    o.fe   = bus.frame_error;
    return o;
  endfunction

  function automatic out_t mko(input logic [3:0] addr, input logic we, input logic [7:0] wd,
                               input logic re, input logic [7:0] txd, input logic tv,
                               input logic fe);
    out_t o;
    o.addr = addr; o.we = we; o.wd = wd; o.re = re; o.txd = txd; o.tv = tv; o.fe = fe;
    return o;
  endfunction

  function automatic vec_t mkv(input logic rv, input logic [7:0] rx, input logic rdv,
                               input logic [7:0] rd, input logic busy, input out_t exp);
    vec_t v;
    v.rv = rv; v.rx = rx; v.rdv = rdv; v.rd = rd; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  // Apply one cycle of inputs; return #1 after the edge that sampled them.
  task automatic cyc(input logic rv, input logic [7:0] rx, input logic rdv,
                     input logic [7:0] rd, input logic busy);
    bus.rx_data_valid   = rv;
    bus.rx_data         = rx;
    bus.read_data_valid = rdv;
    bus.read_data       = rd;
    bus.tx_busy         = busy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic busy);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, busy);
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 8'h00, 1'b0);
  endtask

  // ---------------- frame-level reference model ----------------
  out_t       m;
  logic [7:0] hdr[$];     // opcode and address bytes of the frame in progress
  int         wait_age;   // cycles since the read strobe edge, -1 if not waiting
  bit         sending;    // response captured, waiting for the transmitter

  task automatic model_reset();
    m        = '0;
    hdr.delete();
    wait_age = -1;
    sending  = 1'b0;
  endtask

  task automatic model_step(input logic rv, input logic [7:0] rx, input logic rdv,
                            input logic [7:0] rd, input logic busy);
    m.we = 1'b0; m.re = 1'b0; m.tv = 1'b0; m.fe = 1'b0;
    if (sending) begin
      m.fe = rv;
      if (!busy) begin
        m.tv    = 1'b1;
        sending = 1'b0;
      end
    end else if (wait_age >= 0) begin
      m.fe = rv;
      wait_age++;
      if (rdv) begin
        m.txd    = rd;
        sending  = 1'b1;
        wait_age = -1;
      end else if (wait_age == 5) begin
        m.fe     = 1'b1;
        wait_age = -1;
      end
    end else if (rv) begin
      hdr.push_back(rx);
      if (hdr[0] != WR && hdr[0] != RD) begin
        hdr.delete();
      end else if (hdr.size() == 2) begin
        m.addr = hdr[1][3:0];
        if (hdr[0] == RD) begin
          m.re     = 1'b1;
          wait_age = 0;
          hdr.delete();
        end
      end else if (hdr.size() == 3) begin
        m.wd = rx;
        m.we = 1'b1;
        hdr.delete();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   cnt;
    out_t o;

    // Basic frames, cycle by cycle from reset.
    vecs.push_back(mkv(1, 8'hAA, 0, 8'h00, 0, mko(4'h0, 0, 8'h00, 0, 8'h00, 0, 0)));
    vecs.push_back(mkv(1, 8'h03, 0, 8'h00, 0, mko(4'h3, 0, 8'h00, 0, 8'h00, 0, 0)));
    vecs.push_back(mkv(1, 8'h5C, 0, 8'h00, 0, mko(4'h3, 1, 8'h5C, 0, 8'h00, 0, 0)));
    vecs.push_back(mkv(0, 8'h00, 0, 8'h00, 0, mko(4'h3, 0, 8'h5C, 0, 8'h00, 0, 0)));
    vecs.push_back(mkv(1, 8'hBB, 0, 8'h00, 0, mko(4'h3, 0, 8'h5C, 0, 8'h00, 0, 0)));
    vecs.push_back(mkv(1, 8'h02, 0, 8'h00, 0, mko(4'h2, 0, 8'h5C, 1, 8'h00, 0, 0)));
    vecs.push_back(mkv(0, 8'h00, 0, 8'h00, 0, mko(4'h2, 0, 8'h5C, 0, 8'h00, 0, 0)));
    vecs.push_back(mkv(0, 8'h00, 1, 8'h21, 0, mko(4'h2, 0, 8'h5C, 0, 8'h21, 0, 0)));
    vecs.push_back(mkv(0, 8'h00, 0, 8'h00, 0, mko(4'h2, 0, 8'h5C, 0, 8'h21, 1, 0)));
    vecs.push_back(mkv(0, 8'h00, 0, 8'h00, 0, mko(4'h2, 0, 8'h5C, 0, 8'h21, 0, 0)));
    vecs.push_back(mkv(1, 8'h3C, 0, 8'h00, 0, mko(4'h2, 0, 8'h5C, 0, 8'h21, 0, 0)));
    vecs.push_back(mkv(1, 8'hAA, 0, 8'h00, 0, mko(4'h2, 0, 8'h5C, 0, 8'h21, 0, 0)));
    vecs.push_back(mkv(1, 8'hF9, 0, 8'h00, 0, mko(4'h9, 0, 8'h5C, 0, 8'h21, 0, 0)));
    vecs.push_back(mkv(1, 8'h01, 0, 8'h00, 0, mko(4'h9, 1, 8'h01, 0, 8'h21, 0, 0)));
    vecs.push_back(mkv(1, 8'hAA, 0, 8'h00, 0, mko(4'h9, 0, 8'h01, 0, 8'h21, 0, 0)));
    vecs.push_back(mkv(1, 8'h07, 0, 8'h00, 0, mko(4'h7, 0, 8'h01, 0, 8'h21, 0, 0)));
    vecs.push_back(mkv(1, 8'h80, 0, 8'h00, 0, mko(4'h7, 1, 8'h80, 0, 8'h21, 0, 0)));
    vecs.push_back(mkv(0, 8'h00, 0, 8'h00, 0, mko(4'h7, 0, 8'h80, 0, 8'h21, 0, 0)));

    // Reset state.
    reset = 1'b0;
    bus.rx_data_valid = 1'b0; bus.rx_data = '0; bus.read_data_valid = 1'b0;
    bus.read_data = '0; bus.tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(get_out()), 32'(out_t'('0)));
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rv, vecs[i].rx, vecs[i].rdv, vecs[i].rd, vecs[i].busy);
      check($sformatf("vector_%0d", i), 32'(get_out()), 32'(vecs[i].exp));
    end

    // Backpressure: tx_data_valid only in the first cycle after tx_busy drops.
    send(RD);
    send(8'h01);
    check("bp_read_enable", {28'h0, bus.address, 3'b0, bus.read_enable}, {28'h1, 4'h1});
    idle(1'b1);
    cyc(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1);
    check("bp_captured", 32'(bus.tx_data), 32'h5A);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      cnt += int'(bus.tx_data_valid);
    end
    check("bp_no_pulse_while_busy", 32'(cnt), 32'd0);
    idle(1'b0);
    check("bp_pulse", {23'h0, bus.tx_data_valid, bus.tx_data}, {23'h0, 1'b1, 8'h5A});
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      cnt += int'(bus.tx_data_valid);
    end
    check("bp_single_pulse", 32'(cnt), 32'd0);

    // Timeout: frame_error 5 cycles after the read_enable cycle, tx_data kept.
    send(RD);
    send(8'h07);
    check("to_read_enable", 32'(bus.read_enable), 32'd1);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      cnt += int'(bus.frame_error);
    end
    check("to_no_early_error", 32'(cnt), 32'd0);
    idle(1'b0);
    check("to_error_pulse", 32'(bus.frame_error), 32'd1);
    check("to_tx_data_kept", 32'(bus.tx_data), 32'h5A);
    idle(1'b0);
    check("to_error_once", 32'(bus.frame_error), 32'd0);
    send(WR);
    send(8'h00);
    send(8'hFF);
    check("to_followup_write", 32'(get_out()), 32'(mko(4'h0, 1, 8'hFF, 0, 8'h5A, 0, 0)));

    // Drops in READ_WAIT and SEND; read still completes.
    send(RD);
    send(8'h06);
    send(8'h55);
    check("drop_wait_error", 32'(get_out()), 32'(mko(4'h6, 0, 8'hFF, 0, 8'h5A, 0, 1)));
    cyc(1'b0, 8'h00, 1'b1, 8'hC3, 1'b1);
    check("drop_capture", 32'(get_out()), 32'(mko(4'h6, 0, 8'hFF, 0, 8'hC3, 0, 0)));
    cyc(1'b1, WR, 1'b0, 8'h00, 1'b1);
    check("drop_send_error", 32'(get_out()), 32'(mko(4'h6, 0, 8'hFF, 0, 8'hC3, 0, 1)));
    idle(1'b0);
    check("drop_send_pulse", 32'(get_out()), 32'(mko(4'h6, 0, 8'hFF, 0, 8'hC3, 1, 0)));

    // Reset mid-frame: the frame is abandoned, following bytes decode as opcodes.
    send(WR);
    send(8'h04);
    check("rst_addr_before", 32'(bus.address), 32'h4);
    reset = 1'b0;
    #2;
    check("rst_async_clear", 32'(get_out()), 32'(out_t'('0)));
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(8'h11);
    check("rst_byte_11", 32'(get_out()), 32'(out_t'('0)));
    send(8'h22);
    check("rst_byte_22", 32'(get_out()), 32'(out_t'('0)));
    idle(1'b0);
    check("rst_no_write", 32'(get_out()), 32'(out_t'('0)));

    // Randomized traffic against the model.
    reset = 1'b0;
    idle(1'b0);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic       rv, rdv, busy;
      logic [7:0] rx, rd;
      int         pick;
      rv   = ($urandom_range(0, 9) < 4);
      pick = int'($urandom_range(0, 9));
      rx   = (pick < 3) ? WR : (pick < 6) ? RD : 8'($urandom);
      rdv  = ($urandom_range(0, 3) == 0);
      rd   = 8'($urandom);
      busy = 1'($urandom_range(0, 1));
      cyc(rv, rx, rdv, rd, busy);
      model_step(rv, rx, rdv, rd, busy);
      o = get_out();
      check($sformatf("random_cycle_%0d", i), 32'(o), 32'(m));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
